// File: rtl/coh_pkg.sv
// Package for the two-core snoop-based coherence controller.
// Holds the MSI line-state encoding, the controller state type, the
// core count and the latched-request record shared by the controller.
// Optional feature macro used by the controller: COH_SNP_STAT_EN.
package coh_pkg;

    localparam int NUM_CORE   = 2;
    localparam int COH_ADDR_W = 32;
    localparam int COH_DATA_W = 32;

    typedef enum logic [1:0] {
        INCOR = 2'b00,
        SHARE = 2'b01,
        MODIF = 2'b10
    } msi_type;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        SNOOP,
        SNP_RESP,
        MEM_WR,
        MEM_RD,
        DONE
    } ctrl_state_type;

    // One pending L1 request; widths follow COH_ADDR_W / COH_DATA_W.
    typedef struct packed {
        logic                  is_we;
        logic [COH_ADDR_W-1:0] addr;
        logic [COH_DATA_W-1:0] wdata;
    } req_type;

endpackage

// File: rtl/coh_snoop_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> core 0)
//   req[1:0]  : request vector
//   advance   : a grant is being taken this cycle; pointer moves past it
//   gnt[1:0]  : one-hot grant (combinational from req and pointer)
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt[ptr_q] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // After a grant the pointer favours the core that was not granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|gnt)) begin
            ptr_d = ~gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/coh_snoop_ctrl.sv
// coh_snoop_ctrl: serialising MSI coherence controller between two L1
// caches and a shared backing memory. One transaction in flight.
//   clk, rst        : clock, asynchronous active-high reset
//   re_l1/we_l1     : per-core read-miss / write pulses
//   addr_l1/Wdata_l1: per-core request address, write data + MSI
//   Rdata_l1/ack_l1 : per-core returned data + MSI, completion pulse
//   re_snp/set_incor_snp/addr_snp : snoop-read / invalidate to other core
//   Rdata_snp/en_out_snp          : snoop data / hit from each core
//   re_mem/we_mem/addr_mem/Wdata_mem/Rdata_mem/ack_mem : memory port
//   snp_hit_cnt     : saturating snoop-hit count (only with COH_SNP_STAT_EN)
// All outputs are registered.
module coh_snoop_ctrl
    import coh_pkg::*;
#(
    parameter int ADDR_W = COH_ADDR_W,
    parameter int DATA_W = COH_DATA_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CORE-1:0]                re_l1,
    input  logic [NUM_CORE-1:0]                we_l1,
    input  logic [NUM_CORE-1:0][ADDR_W-1:0]    addr_l1,
    input  logic [NUM_CORE-1:0][DATA_W+1:0]    Wdata_l1,
    output logic [NUM_CORE-1:0][DATA_W+1:0]    Rdata_l1,
    output logic [NUM_CORE-1:0]                ack_l1,
    output logic [NUM_CORE-1:0]                re_snp,
    output logic [NUM_CORE-1:0]                set_incor_snp,
    output logic [ADDR_W-1:0]                  addr_snp,
    input  logic [NUM_CORE-1:0][DATA_W-1:0]    Rdata_snp,
    input  logic [NUM_CORE-1:0]                en_out_snp,
    output logic                               re_mem,
    output logic                               we_mem,
    output logic [ADDR_W-1:0]                  addr_mem,
    output logic [DATA_W-1:0]                  Wdata_mem,
    input  logic [DATA_W-1:0]                  Rdata_mem,
    input  logic                               ack_mem
`ifdef COH_SNP_STAT_EN
    ,
    output logic [15:0]                        snp_hit_cnt
`endif
);

    ctrl_state_type state_q, state_d;

    logic [NUM_CORE-1:0]             pend_q, pend_d;
    req_type [NUM_CORE-1:0]          req_q, req_d;
    req_type                         cur_q, cur_d;
    logic                            g_q, g_d;
    logic [DATA_W-1:0]               snp_data_q, snp_data_d;

    logic [NUM_CORE-1:0][DATA_W+1:0] rdata_l1_q, rdata_l1_d;
    logic [NUM_CORE-1:0]             ack_l1_q, ack_l1_d;
    logic [NUM_CORE-1:0]             re_snp_q, re_snp_d;
    logic [NUM_CORE-1:0]             set_incor_q, set_incor_d;
    logic [ADDR_W-1:0]               addr_snp_q, addr_snp_d;
    logic                            re_mem_q, re_mem_d;
    logic                            we_mem_q, we_mem_d;
    logic [ADDR_W-1:0]               addr_mem_q, addr_mem_d;
    logic [DATA_W-1:0]               wdata_mem_q, wdata_mem_d;
`ifdef COH_SNP_STAT_EN
    logic [15:0]                     hit_cnt_q, hit_cnt_d;
`endif

    logic [1:0] arb_gnt;
    logic       arb_adv;
    logic       gidx;
    logic       oth;

    // MSI bits of the write bus never reach memory.
    logic       msi_unused;
    assign msi_unused = ^{Wdata_l1[1][DATA_W+1:DATA_W], Wdata_l1[0][DATA_W+1:DATA_W]};

    assign gidx = arb_gnt[1];
    assign oth  = ~g_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pend_q),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        req_d       = req_q;
        cur_d       = cur_q;
        g_d         = g_q;
        snp_data_d  = snp_data_q;
        rdata_l1_d  = rdata_l1_q;
        ack_l1_d    = '0;
        re_snp_d    = '0;
        set_incor_d = '0;
        addr_snp_d  = addr_snp_q;
        re_mem_d    = re_mem_q;
        we_mem_d    = we_mem_q;
        addr_mem_d  = addr_mem_q;
        wdata_mem_d = wdata_mem_q;
        arb_adv     = 1'b0;
`ifdef COH_SNP_STAT_EN
        hit_cnt_d   = hit_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    arb_adv      = 1'b1;
                    g_d          = gidx;
                    cur_d        = req_q[gidx];
                    pend_d[gidx] = 1'b0;
                    addr_snp_d   = req_q[gidx].addr;
                    if (req_q[gidx].is_we) begin
                        set_incor_d[~gidx] = 1'b1;
                        state_d            = INV;
                    end else begin
                        re_snp_d[~gidx] = 1'b1;
                        state_d         = SNOOP;
                    end
                end
            end
            INV: begin
                we_mem_d    = 1'b1;
                addr_mem_d  = cur_q.addr;
                wdata_mem_d = cur_q.wdata;
                state_d     = MEM_WR;
            end
            SNOOP: begin
                state_d = SNP_RESP;
            end
            SNP_RESP: begin
                addr_mem_d = cur_q.addr;
                if (en_out_snp[oth]) begin
                    // Hit: push the snooped line to memory before answering.
                    snp_data_d  = Rdata_snp[oth];
                    wdata_mem_d = Rdata_snp[oth];
                    we_mem_d    = 1'b1;
                    state_d     = MEM_WR;
`ifdef COH_SNP_STAT_EN
                    if (hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
`endif
                end else begin
                    re_mem_d = 1'b1;
                    state_d  = MEM_RD;
                end
            end
            MEM_WR: begin
                if (ack_mem) begin
                    we_mem_d      = 1'b0;
                    ack_l1_d[g_q] = 1'b1;
                    if (!cur_q.is_we) begin
                        rdata_l1_d[g_q] = {SHARE, snp_data_q};
                    end
                    state_d = DONE;
                end
            end
            MEM_RD: begin
                if (ack_mem) begin
                    re_mem_d        = 1'b0;
                    ack_l1_d[g_q]   = 1'b1;
                    rdata_l1_d[g_q] = {SHARE, Rdata_mem};
                    state_d         = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New pulses are latched after the grant clear so a pulse in the
        // grant cycle is never lost; write wins over a simultaneous read.
        for (int unsigned i = 0; i < NUM_CORE; i++) begin
            if (we_l1[i]) begin
                pend_d[i] = 1'b1;
                req_d[i]  = '{is_we: 1'b1, addr: addr_l1[i], wdata: Wdata_l1[i][DATA_W-1:0]};
            end else if (re_l1[i]) begin
                pend_d[i] = 1'b1;
                req_d[i]  = '{is_we: 1'b0, addr: addr_l1[i], wdata: '0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            req_q       <= '0;
            cur_q       <= '0;
            g_q         <= 1'b0;
            snp_data_q  <= '0;
            rdata_l1_q  <= '0;
            ack_l1_q    <= '0;
            re_snp_q    <= '0;
            set_incor_q <= '0;
            addr_snp_q  <= '0;
            re_mem_q    <= 1'b0;
            we_mem_q    <= 1'b0;
            addr_mem_q  <= '0;
            wdata_mem_q <= '0;
`ifdef COH_SNP_STAT_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            req_q       <= req_d;
            cur_q       <= cur_d;
            g_q         <= g_d;
            snp_data_q  <= snp_data_d;
            rdata_l1_q  <= rdata_l1_d;
            ack_l1_q    <= ack_l1_d;
            re_snp_q    <= re_snp_d;
            set_incor_q <= set_incor_d;
            addr_snp_q  <= addr_snp_d;
            re_mem_q    <= re_mem_d;
            we_mem_q    <= we_mem_d;
            addr_mem_q  <= addr_mem_d;
            wdata_mem_q <= wdata_mem_d;
`ifdef COH_SNP_STAT_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    assign Rdata_l1      = rdata_l1_q;
    assign ack_l1        = ack_l1_q;
    assign re_snp        = re_snp_q;
    assign set_incor_snp = set_incor_q;
    assign addr_snp      = addr_snp_q;
    assign re_mem        = re_mem_q;
    assign we_mem        = we_mem_q;
    assign addr_mem      = addr_mem_q;
    assign Wdata_mem     = wdata_mem_q;
`ifdef COH_SNP_STAT_EN
    assign snp_hit_cnt   = hit_cnt_q;
`endif

endmodule
